// File: rtl/hsv_blob_tracker_if.sv
// Pixel stream carrying one HSV sample per in_valid cycle plus frame markers.
//   h        : hue 0..255
//   s        : saturation 0..255
//   v        : value 0..63
//   in_valid : h/s/v/sof/eof qualify this cycle
//   sof      : with in_valid, first pixel of a frame
//   eof      : with in_valid, last pixel of a frame (included)
// master drives the stream, slave consumes it.
interface hsv_blob_tracker_if;
  logic [7:0] h;
  logic [7:0] s;
  logic [5:0] v;
  logic       in_valid;
  logic       sof;
  logic       eof;

  modport master (output h, s, v, in_valid, sof, eof);
  modport slave  (input  h, s, v, in_valid, sof, eof);
endinterface

// File: rtl/hsv_blob_tracker.sv
// Classifies each HSV pixel against a programmable colour window, accumulates
// the count and coordinate sums of matching pixels per frame, and at end of
// frame divides the sums by the count to produce the blob centroid.
//   clk, rst       : clock, asynchronous active-high reset
//   pix            : HSV pixel stream (slave side)
//   hue_lo/hue_hi  : hue window; hue_lo > hue_hi selects a wrap-around window
//   sat_min/val_min: minimum saturation / value
//   blob_x/blob_y  : centroid of matching pixels in the last completed frame
//   blob_count     : matching pixels in that frame (saturating)
//   blob_found     : blob_count >= MIN_PIXELS
//   result_valid   : one-cycle pulse when the blob outputs update
//   frame_dropped  : one-cycle pulse when a finished frame found the divider busy
//   match          : registered per-pixel match flag
module hsv_blob_tracker #(
  parameter int unsigned IMG_W      = 160,
  parameter int unsigned IMG_H      = 120,
  parameter int unsigned X_BITS     = 8,
  parameter int unsigned Y_BITS     = 7,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned SUM_W      = 24,
  parameter int unsigned MIN_PIXELS = 16
) (
  input  logic                clk,
  input  logic                rst,
  hsv_blob_tracker_if.slave   pix,
  input  logic [7:0]          hue_lo,
  input  logic [7:0]          hue_hi,
  input  logic [7:0]          sat_min,
  input  logic [5:0]          val_min,
  output logic [X_BITS-1:0]   blob_x,
  output logic [Y_BITS-1:0]   blob_y,
  output logic [CNT_W-1:0]    blob_count,
  output logic                blob_found,
  output logic                result_valid,
  output logic                frame_dropped,
  output logic                match
);

  localparam int unsigned STEP_W = $clog2(SUM_W);

  if (longint'(IMG_W) * longint'(IMG_H) * longint'(IMG_W - 1) >= (longint'(1) << SUM_W)) begin : g_sum_w_check
    $error("SUM_W cannot hold the largest coordinate sum");
  end

  typedef enum logic {WAIT_SOF, ACCUM} acc_state_t;
  typedef enum logic [1:0] {D_IDLE, D_RUN, D_DONE} div_state_t;

  acc_state_t        acc_state_q;
  div_state_t        div_state_q;

  logic [7:0]        hue_lo_q, hue_hi_q, sat_min_q;
  logic [5:0]        val_min_q;
  logic [X_BITS-1:0] x_q;
  logic [Y_BITS-1:0] y_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SUM_W-1:0]  sum_x_q, sum_y_q;

  logic              hand_q;
  logic [CNT_W-1:0]  hand_cnt_q;
  logic [SUM_W-1:0]  hand_sx_q, hand_sy_q;

  logic [CNT_W-1:0]  div_q, rem_x_q, rem_y_q;
  logic [SUM_W-1:0]  quo_x_q, quo_y_q;
  logic [STEP_W-1:0] step_q;

  logic [X_BITS-1:0] blob_x_q;
  logic [Y_BITS-1:0] blob_y_q;
  logic [CNT_W-1:0]  blob_count_q;
  logic              blob_found_q, result_valid_q, frame_dropped_q, match_q;

  // Combinational pixel path
  logic [7:0]        lo_e, hi_e, smin_e;
  logic [5:0]        vmin_e;
  logic              hue_ok, match_c, take, last_col, busy;
  logic [X_BITS-1:0] cur_x;
  logic [Y_BITS-1:0] cur_y;
  logic [CNT_W-1:0]  base_cnt, cnt_d;
  logic [SUM_W-1:0]  base_sx, base_sy, sum_x_d, sum_y_d;
  logic [CNT_W-1:0]  rem_x_d, rem_y_d;
  logic [SUM_W-1:0]  quo_x_d, quo_y_d;

  // One restoring-division step: shift the next dividend bit into the
  // remainder, subtract the divisor if it fits, shift the quotient bit in.
  // The dividend register doubles as the quotient register.
  function automatic logic [CNT_W+SUM_W-1:0] div_step(
    input logic [CNT_W-1:0] rem,
    input logic [SUM_W-1:0] quo,
    input logic [CNT_W-1:0] d
  );
    logic [CNT_W:0] rs;
    logic           ge;
    rs = {rem, quo[SUM_W-1]};
    ge = (rs >= {1'b0, d});
    // When ge holds the true difference is below d, so CNT_W bits suffice.
    div_step = {(ge ? (rs[CNT_W-1:0] - d) : rs[CNT_W-1:0]), quo[SUM_W-2:0], ge};
  endfunction

  always_comb begin
    // An sof pixel is judged by the thresholds being sampled with it.
    lo_e     = pix.sof ? hue_lo  : hue_lo_q;
    hi_e     = pix.sof ? hue_hi  : hue_hi_q;
    smin_e   = pix.sof ? sat_min : sat_min_q;
    vmin_e   = pix.sof ? val_min : val_min_q;
    hue_ok   = (lo_e <= hi_e) ? ((pix.h >= lo_e) && (pix.h <= hi_e))
                              : ((pix.h >= lo_e) || (pix.h <= hi_e));
    match_c  = hue_ok && (pix.s >= smin_e) && (pix.v >= vmin_e);
    take     = pix.in_valid && (pix.sof || (acc_state_q == ACCUM));
    cur_x    = pix.sof ? '0 : x_q;
    cur_y    = pix.sof ? '0 : y_q;
    base_cnt = pix.sof ? '0 : cnt_q;
    base_sx  = pix.sof ? '0 : sum_x_q;
    base_sy  = pix.sof ? '0 : sum_y_q;
    cnt_d    = (match_c && (base_cnt != '1)) ? base_cnt + CNT_W'(1) : base_cnt;
    sum_x_d  = match_c ? base_sx + SUM_W'(cur_x) : base_sx;
    sum_y_d  = match_c ? base_sy + SUM_W'(cur_y) : base_sy;
    last_col = (cur_x == X_BITS'(IMG_W - 1));
    // A pending handoff counts as busy: the divider takes it next cycle.
    busy     = hand_q || (div_state_q != D_IDLE);
    {rem_x_d, quo_x_d} = div_step(rem_x_q, quo_x_q, div_q);
    {rem_y_d, quo_y_d} = div_step(rem_y_q, quo_y_q, div_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_state_q     <= WAIT_SOF;
      hue_lo_q        <= '0;
      hue_hi_q        <= '0;
      sat_min_q       <= '0;
      val_min_q       <= '0;
      x_q             <= '0;
      y_q             <= '0;
      cnt_q           <= '0;
      sum_x_q         <= '0;
      sum_y_q         <= '0;
      hand_q          <= 1'b0;
      hand_cnt_q      <= '0;
      hand_sx_q       <= '0;
      hand_sy_q       <= '0;
      frame_dropped_q <= 1'b0;
      match_q         <= 1'b0;
    end else begin
      hand_q          <= 1'b0;
      frame_dropped_q <= 1'b0;
      match_q         <= take && match_c;
      if (take) begin
        if (pix.sof) begin
          hue_lo_q  <= hue_lo;
          hue_hi_q  <= hue_hi;
          sat_min_q <= sat_min;
          val_min_q <= val_min;
        end
        if (pix.eof) begin
          acc_state_q <= WAIT_SOF;
          x_q         <= '0;
          y_q         <= '0;
          cnt_q       <= '0;
          sum_x_q     <= '0;
          sum_y_q     <= '0;
          if (busy) begin
            frame_dropped_q <= 1'b1;
          end else begin
            hand_q     <= 1'b1;
            hand_cnt_q <= cnt_d;
            hand_sx_q  <= sum_x_d;
            hand_sy_q  <= sum_y_d;
          end
        end else begin
          acc_state_q <= ACCUM;
          cnt_q       <= cnt_d;
          sum_x_q     <= sum_x_d;
          sum_y_q     <= sum_y_d;
          x_q         <= last_col ? '0 : cur_x + X_BITS'(1);
          y_q         <= last_col ? cur_y + Y_BITS'(1) : cur_y;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_state_q    <= D_IDLE;
      div_q          <= '0;
      rem_x_q        <= '0;
      rem_y_q        <= '0;
      quo_x_q        <= '0;
      quo_y_q        <= '0;
      step_q         <= '0;
      blob_x_q       <= '0;
      blob_y_q       <= '0;
      blob_count_q   <= '0;
      blob_found_q   <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (div_state_q)
        D_IDLE: begin
          if (hand_q) begin
            div_q       <= hand_cnt_q;
            quo_x_q     <= hand_sx_q;
            quo_y_q     <= hand_sy_q;
            rem_x_q     <= '0;
            rem_y_q     <= '0;
            step_q      <= '0;
            div_state_q <= D_RUN;
          end
        end
        D_RUN: begin
          rem_x_q <= rem_x_d;
          rem_y_q <= rem_y_d;
          quo_x_q <= quo_x_d;
          quo_y_q <= quo_y_d;
          step_q  <= step_q + STEP_W'(1);
          if (step_q == STEP_W'(SUM_W - 1)) begin
            div_state_q <= D_DONE;
          end
        end
        D_DONE: begin
          if (div_q == '0) begin
            blob_x_q     <= '0;
            blob_y_q     <= '0;
            blob_count_q <= '0;
            blob_found_q <= 1'b0;
          end else begin
            blob_x_q     <= quo_x_q[X_BITS-1:0];
            blob_y_q     <= quo_y_q[Y_BITS-1:0];
            blob_count_q <= div_q;
            blob_found_q <= (div_q >= CNT_W'(MIN_PIXELS));
          end
          result_valid_q <= 1'b1;
          div_state_q    <= D_IDLE;
        end
        default: div_state_q <= D_IDLE;
      endcase
    end
  end

  assign blob_x        = blob_x_q;
  assign blob_y        = blob_y_q;
  assign blob_count    = blob_count_q;
  assign blob_found    = blob_found_q;
  assign result_valid  = result_valid_q;
  assign frame_dropped = frame_dropped_q;
  assign match         = match_q;

endmodule

// File: tb/tb_hsv_blob_tracker.sv
// Bench for hsv_blob_tracker: two instances (MIN_PIXELS=1 and 16) share one
// 4-pixel-wide stream. Expected match flags, frame results and dropped-frame
// pulses are queued as stimulus is driven and checked when the DUT emits them.
module tb_hsv_blob_tracker;
  localparam int unsigned IMG_W = 4;
  localparam int unsigned SUM_W = 24;
  localparam int unsigned LAT   = SUM_W + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hsv_blob_tracker_if pix();
  logic [7:0] hue_lo, hue_hi, sat_min;
  logic [5:0] val_min;

  logic [7:0]  a_bx, b_bx;
  logic [6:0]  a_by, b_by;
  logic [15:0] a_cnt, b_cnt;
  logic        a_found, b_found, a_rv, b_rv, a_fd, b_fd, a_match, b_match;

  hsv_blob_tracker #(.IMG_W(IMG_W), .SUM_W(SUM_W), .MIN_PIXELS(1)) u_dut_a (
    .clk(clk), .rst(rst), .pix(pix),
    .hue_lo(hue_lo), .hue_hi(hue_hi), .sat_min(sat_min), .val_min(val_min),
    .blob_x(a_bx), .blob_y(a_by), .blob_count(a_cnt), .blob_found(a_found),
    .result_valid(a_rv), .frame_dropped(a_fd), .match(a_match)
  );

  hsv_blob_tracker #(.IMG_W(IMG_W), .SUM_W(SUM_W), .MIN_PIXELS(16)) u_dut_b (
    .clk(clk), .rst(rst), .pix(pix),
    .hue_lo(hue_lo), .hue_hi(hue_hi), .sat_min(sat_min), .val_min(val_min),
    .blob_x(b_bx), .blob_y(b_by), .blob_count(b_cnt), .blob_found(b_found),
    .result_valid(b_rv), .frame_dropped(b_fd), .match(b_match)
  );

  typedef struct {
    int          cyc;
    logic [15:0] cnt;
    logic [7:0]  bx;
    logic [6:0]  by;
  } res_t;

  typedef struct {
    logic [7:0] lo, hi, smin;
    logic [5:0] vmin;
    logic [7:0] h, s;
    logic [5:0] v;
    logic       exp_m;
  } mvec_t;

  res_t rq[$];
  int   dq[$];
  logic mq[$];

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic vld_seen = 1'b0;

  // Reference frame model
  int     mx, my, mcnt;
  longint msx, msy;
  bit     mact = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit ref_match(input logic [7:0] h, input logic [7:0] s, input logic [5:0] v);
    bit hok;
    if (hue_lo <= hue_hi) hok = (h >= hue_lo) && (h <= hue_hi);
    else                  hok = (h >= hue_lo) || (h <= hue_hi);
    return hok && (s >= sat_min) && (v >= val_min);
  endfunction

  always @(posedge clk) begin
    cyc      = cyc + 1;
    vld_seen = pix.in_valid && !rst;
  end

  logic em;
  res_t e;
  int   dc;
  always @(negedge clk) begin
    if (vld_seen) begin
      if (mq.size() == 0) chk("match_queue_depth", mq.size(), 1);
      else begin
        em = mq.pop_front();
        chk("match_a", a_match, em);
        chk("match_b", b_match, em);
      end
    end
    if (a_rv || b_rv) begin
      chk("result_valid_pair", b_rv, a_rv);
      if (rq.size() == 0) chk("unexpected_result_valid", a_rv, 0);
      else begin
        e = rq.pop_front();
        chk("result_cycle", cyc, e.cyc);
        chk("blob_count_a", a_cnt, e.cnt);
        chk("blob_count_b", b_cnt, e.cnt);
        chk("blob_x_a", a_bx, e.bx);
        chk("blob_x_b", b_bx, e.bx);
        chk("blob_y_a", a_by, e.by);
        chk("blob_y_b", b_by, e.by);
        chk("blob_found_a", a_found, e.cnt >= 1);
        chk("blob_found_b", b_found, e.cnt >= 16);
      end
    end
    if (a_fd || b_fd) begin
      chk("frame_dropped_pair", b_fd, a_fd);
      if (dq.size() == 0) chk("unexpected_frame_dropped", a_fd, 0);
      else begin
        dc = dq.pop_front();
        chk("frame_dropped_cycle", cyc, dc);
      end
    end
  end

  // Called just after a negedge; holds the pixel across one posedge.
  task automatic drive(input logic [7:0] h, input logic [7:0] s, input logic [5:0] v,
                       input bit sof, input bit eof, input bit exp_m, input bit drop);
    res_t r;
    pix.h = h; pix.s = s; pix.v = v;
    pix.sof = sof; pix.eof = eof; pix.in_valid = 1'b1;
    if (sof) begin
      mact = 1'b1; mx = 0; my = 0; mcnt = 0; msx = 0; msy = 0;
    end
    if (mact) begin
      mq.push_back(exp_m);
      if (exp_m) begin
        mcnt++; msx += mx; msy += my;
      end
      if (eof) begin
        if (drop) dq.push_back(cyc + 1);
        else begin
          r.cyc = cyc + 1 + LAT;
          r.cnt = 16'(mcnt);
          r.bx  = (mcnt == 0) ? 8'd0 : 8'(msx / mcnt);
          r.by  = (mcnt == 0) ? 7'd0 : 7'(msy / mcnt);
          rq.push_back(r);
        end
        mact = 1'b0;
      end else if (mx == IMG_W - 1) begin
        mx = 0; my++;
      end else mx++;
    end else mq.push_back(1'b0);
    @(negedge clk);
    pix.in_valid = 1'b0; pix.sof = 1'b0; pix.eof = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] hs [16], input int npix, input bit with_eof);
    for (int i = 0; i < npix; i++)
      drive(hs[i], 8'd200, 6'd40, i == 0, with_eof && (i == npix - 1),
            ref_match(hs[i], 8'd200, 6'd40), 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_blob_x"},  {a_bx, b_bx}, 0);
    chk({tag, "_blob_y"},  {a_by, b_by}, 0);
    chk({tag, "_count"},   {a_cnt, b_cnt}, 0);
    chk({tag, "_flags"},   {a_found, b_found, a_rv, b_rv, a_fd, b_fd, a_match, b_match}, 0);
  endtask

  mvec_t      mv [16];
  logic [7:0] fr [16];
  logic [7:0] fa [16];

  initial begin
    // Hand-written expectations for the classifier.
    mv[0]  = '{8'd250, 8'd10, 8'd0,   6'd0,  8'd5,   8'd0,   6'd0,  1'b1};
    mv[1]  = '{8'd250, 8'd10, 8'd0,   6'd0,  8'd252, 8'd0,   6'd0,  1'b1};
    mv[2]  = '{8'd250, 8'd10, 8'd0,   6'd0,  8'd128, 8'd0,   6'd0,  1'b0};
    mv[3]  = '{8'd250, 8'd10, 8'd100, 6'd0,  8'd5,   8'd99,  6'd0,  1'b0};
    mv[4]  = '{8'd250, 8'd10, 8'd100, 6'd0,  8'd5,   8'd100, 6'd0,  1'b1};
    mv[5]  = '{8'd250, 8'd10, 8'd0,   6'd0,  8'd10,  8'd0,   6'd0,  1'b1};
    mv[6]  = '{8'd250, 8'd10, 8'd0,   6'd0,  8'd11,  8'd0,   6'd0,  1'b0};
    mv[7]  = '{8'd250, 8'd10, 8'd0,   6'd0,  8'd250, 8'd0,   6'd0,  1'b1};
    mv[8]  = '{8'd250, 8'd10, 8'd0,   6'd0,  8'd249, 8'd0,   6'd0,  1'b0};
    mv[9]  = '{8'd40,  8'd60, 8'd0,   6'd0,  8'd40,  8'd0,   6'd0,  1'b1};
    mv[10] = '{8'd40,  8'd60, 8'd0,   6'd0,  8'd60,  8'd0,   6'd0,  1'b1};
    mv[11] = '{8'd40,  8'd60, 8'd0,   6'd0,  8'd39,  8'd0,   6'd0,  1'b0};
    mv[12] = '{8'd40,  8'd60, 8'd0,   6'd0,  8'd61,  8'd0,   6'd0,  1'b0};
    mv[13] = '{8'd40,  8'd60, 8'd0,   6'd20, 8'd50,  8'd255, 6'd19, 1'b0};
    mv[14] = '{8'd40,  8'd60, 8'd0,   6'd20, 8'd50,  8'd255, 6'd20, 1'b1};
    mv[15] = '{8'd40,  8'd60, 8'd200, 6'd0,  8'd50,  8'd199, 6'd63, 1'b0};

    pix.h = '0; pix.s = '0; pix.v = '0;
    pix.in_valid = 1'b0; pix.sof = 1'b0; pix.eof = 1'b0;
    hue_lo = '0; hue_hi = '0; sat_min = '0; val_min = '0;

    rst = 1'b1;
    idle(3);
    chk_zero("reset");
    rst = 1'b0;
    idle(2);

    // Each vector is an sof pixel, so its own thresholds apply.
    for (int i = 0; i < 16; i++) begin
      hue_lo = mv[i].lo; hue_hi = mv[i].hi; sat_min = mv[i].smin; val_min = mv[i].vmin;
      drive(mv[i].h, mv[i].s, mv[i].v, 1'b1, 1'b0, mv[i].exp_m, 1'b0);
    end

    hue_lo = 8'd40; hue_hi = 8'd60; sat_min = 8'd0; val_min = 6'd0;

    // Four matches at (1,1),(3,1),(1,3),(3,3) -> centroid (2,2).
    for (int i = 0; i < 16; i++) fa[i] = 8'd0;
    fa[5] = 8'd50; fa[7] = 8'd50; fa[13] = 8'd50; fa[15] = 8'd50;
    send_frame(fa, 16, 1'b1);
    idle(LAT + 4);

    // No matches.
    for (int i = 0; i < 16; i++) fr[i] = 8'd0;
    send_frame(fr, 16, 1'b1);
    idle(LAT + 4);

    // Partial frame of 7 matches abandoned by a new sof.
    for (int i = 0; i < 16; i++) fr[i] = 8'd50;
    send_frame(fr, 7, 1'b0);
    for (int i = 0; i < 16; i++) fr[i] = 8'd0;
    fr[0] = 8'd50; fr[2] = 8'd50;
    send_frame(fr, 16, 1'b1);
    idle(LAT + 4);

    // Pseudo-random hues around the window.
    for (int i = 0; i < 16; i++) fr[i] = 8'($urandom_range(30, 70));
    send_frame(fr, 16, 1'b1);
    idle(LAT + 4);

    // Back-to-back one-pixel frames: second arrives while the first is pending.
    drive(8'd50, 8'd200, 6'd40, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(8'd50, 8'd200, 6'd40, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(LAT + 4);

    // Reset while the divider runs.
    send_frame(fa, 16, 1'b1);
    idle(10);
    rst = 1'b1;
    #1;
    chk_zero("abort");
    chk("aborted_pending", rq.size(), 1);
    if (rq.size() != 0) void'(rq.pop_back());
    idle(2);
    rst = 1'b0;
    idle(LAT + 4);

    send_frame(fa, 16, 1'b1);
    idle(LAT + 4);

    idle(5);
    chk("results_outstanding", rq.size(), 0);
    chk("drops_outstanding", dq.size(), 0);
    chk("matches_outstanding", mq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hsv_blob_tracker.md
Name: hsv_blob_tracker

Overview:
- Consumes the per-pixel HSV stream produced by rgb_to_hsv: h, s, v plus its valid strobe.
- Adds frame markers from the camera timing path.
- Classifies each pixel against a programmable HSV colour window and accumulates count and coordinate sums of matching pixels per frame.
- At end of frame, computes the blob centroid with a serial divider and presents it to the hexapod tracking controller.

Parameters:
- IMG_W, 160, pixels per line; x counter wraps at IMG_W-1.
- IMG_H, 120, lines per frame (informational; y is not wrapped).
- X_BITS, 8, width of x coordinate and blob_x.
- Y_BITS, 7, width of y coordinate and blob_y.
- CNT_W, 16, width of matching-pixel counter (saturating).
- SUM_W, 24, width of coordinate sums and divider length; must hold IMG_W*IMG_H*(IMG_W-1).
- MIN_PIXELS, 16, minimum match count for a valid detection.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- h  in  8  hue 0..255
- s  in  8  saturation 0..255
- v  in  6  value 0..63
- in_valid  in  1  h/s/v/sof/eof qualify this cycle
- sof  in  1  with in_valid: first pixel of frame, position (0,0)
- eof  in  1  with in_valid: last pixel of frame; this pixel is included
- hue_lo  in  8  hue window low bound
- hue_hi  in  8  hue window high bound
- sat_min  in  8  minimum saturation
- val_min  in  6  minimum value
- blob_x  out  X_BITS  centroid x
- blob_y  out  Y_BITS  centroid y
- blob_count  out  CNT_W  matching pixels in last frame
- blob_found  out  1  blob_count >= MIN_PIXELS
- result_valid  out  1  one-cycle pulse; outputs updated
- frame_dropped  out  1  one-cycle pulse; an eof arrived while the divider was busy
- match  out  1  registered per-pixel match flag, 1-cycle latency, for debug overlay

Behaviour:
- Reset (async, rst=1): all outputs 0, counters/sums 0, accumulator FSM to WAIT_SOF, divider FSM to D_IDLE.
- Thresholds are sampled into shadow registers on each accepted sof pixel and are constant for the frame.
- Match: (s >= sat_min) && (v >= val_min) && hue_ok.
  - hue_ok = (hue_lo <= h <= hue_hi) when hue_lo <= hue_hi.
  - Otherwise (wrap-around window) hue_ok = (h >= hue_lo) || (h <= hue_hi).
  - On an sof pixel, the match uses the incoming thresholds, not the stale shadow registers.
- Accumulator FSM:
  - WAIT_SOF: ignore pixels until in_valid&&sof. That pixel is processed as (0,0); then go to ACCUM.
  - ACCUM: each in_valid pixel advances x; at x==IMG_W-1, x wraps to 0 and y increments.
  - On match: count += 1 (saturating at all-ones); sum_x += x; sum_y += y.
  - in_valid&&sof in ACCUM: discard partial sums and restart at (0,0) with this pixel.
  - in_valid&&eof: include the pixel, hand the final count/sum_x/sum_y to the divider, clear the accumulators, and go to WAIT_SOF.
  - sof&&eof on the same pixel: one-pixel frame, handed off immediately.
- Divider FSM:
  - D_IDLE: on handoff, latch the operands and go to D_RUN.
  - D_RUN: run two parallel restoring dividers, sum_x/count and sum_y/count, one quotient bit per cycle for SUM_W cycles.
  - D_DONE: register the outputs, pulse result_valid, and return to D_IDLE.
  - Latency: eof pixel accepted at cycle N gives result_valid high at cycle N+SUM_W+2.
  - count==0: skip the division result. blob_x=blob_y=0, blob_count=0, blob_found=0, same latency.
  - Quotient is floor, truncated to X_BITS/Y_BITS.
- Handoff while the divider is not D_IDLE: the new frame's results are discarded, frame_dropped pulses that cycle, the in-progress division is unaffected, and the accumulators still clear.
- Outputs hold their values between result_valid pulses.
- rst during D_RUN aborts the division; no result_valid is issued.

Test Plan:
- IMG_W=4, hue 40..60, sat_min=0, val_min=0, MIN_PIXELS=1; 16-pixel frame with h=50 at (1,1),(3,1),(1,3),(3,3), others h=0 -> blob_count=4, blob_x=2, blob_y=2, blob_found=1, result_valid exactly SUM_W+2 cycles after eof.
- Wrap window hue_lo=250, hue_hi=10: pixels h=5, h=252, h=128 -> match 1,1,0. Saturation s=sat_min-1 with matching hue -> match 0.
- Frame with zero matches -> blob_count=0, blob_x=blob_y=0, blob_found=0, result_valid still pulses. MIN_PIXELS=16 with 4 matches -> blob_found=0, blob_count=4.
- Mid-frame sof after 7 matching pixels, then a clean frame with 2 matches at (0,0),(2,0) -> blob_count=2, blob_x=1, blob_y=0.
- Two 1-pixel frames (sof&&eof) on consecutive cycles -> first produces a result, second pulses frame_dropped at the handoff cycle; exactly one result_valid.
- Assert rst mid-D_RUN -> all outputs 0 immediately, no result_valid, next frame processed normally.
